// File: rtl/pipeline_ctrl_pkg.sv
// Shared types and constants for the pipeline control unit.
// Holds the controller FSM states and the register-file zero index.
package pipeline_ctrl_pkg;

   typedef enum logic [1:0] {
      RUN  = 2'd0,
      WAIT = 2'd1,
      HALT = 2'd2
   } ctrl_state_e;

   localparam logic [4:0] REG_ZERO = 5'd0;

   // True when an ID source operand is actually read and names the given register.
   function automatic logic src_match(input logic       uses,
                                      input logic [4:0] src,
                                      input logic [4:0] dst);
      return uses && (src == dst);
   endfunction

endpackage

// File: rtl/pipeline_ctrl_sat_counter.sv
// Saturating up-counter with an increment strobe and a freeze input.
// Used for the stall and flush performance counters.
module sat_counter #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         inc,
   input  logic         freeze,
   output logic [W-1:0] cnt
);

   localparam logic [W-1:0] CNT_MAX = '1;

   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (inc && !freeze && (cnt_q != CNT_MAX)) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt = cnt_q;

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline control unit: load-use, branch-flush and memory-stall handling for the
// five stage registers, with a memory-wait watchdog and saturating perf counters.
module pipeline_ctrl
   import pipeline_ctrl_pkg::*;
#(
   parameter int TIMEOUT = 64,
   parameter int CNT_W   = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [4:0]       id_rs1,
   input  logic [4:0]       id_rs2,
   input  logic             id_uses_rs1,
   input  logic             id_uses_rs2,
   input  logic [4:0]       ex_rd,
   input  logic             ex_mem_read,
   input  logic             ex_branch_taken,
   input  logic             mem_req,
   input  logic             mem_ready,
   output logic             pc_en,
   output logic             ifid_en,
   output logic             idex_en,
   output logic             exmem_en,
   output logic             memwb_en,
   output logic             ifid_clr,
   output logic             idex_clr,
   output logic             memwb_clr,
   output logic             halted,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);

   localparam int WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);

   ctrl_state_e       state_q;
   ctrl_state_e       state_d;
   logic [WAIT_W-1:0] wait_cnt_q;
   logic [WAIT_W-1:0] wait_cnt_d;

   logic mstall;
   logic luse;
   logic stall_inc;
   logic flush_inc;
   logic in_halt;

   assign mstall = mem_req && !mem_ready;
   assign luse   = ex_mem_read && (ex_rd != REG_ZERO) &&
                   (src_match(id_uses_rs1, id_rs1, ex_rd) ||
                    src_match(id_uses_rs2, id_rs2, ex_rd));

   // The counter advances on the cycle the stall is seen, so HALT lands
   // after exactly TIMEOUT consecutive stalled cycles, counting from RUN.
   always_comb begin
      state_d    = state_q;
      wait_cnt_d = '0;
      case (state_q)
         HALT: begin
            state_d = HALT;
         end
         default: begin
            if (mstall) begin
               if ((TIMEOUT != 0) && (wait_cnt_q == WAIT_LAST)) begin
                  state_d = HALT;
               end else begin
                  state_d    = WAIT;
                  wait_cnt_d = wait_cnt_q + 1'b1;
               end
            end else begin
               state_d = RUN;
            end
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= RUN;
         wait_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         wait_cnt_q <= wait_cnt_d;
      end
   end

   // Priority: HALT > memory stall > taken branch > load-use.
   // A branch held in a frozen EX is flushed only once mem_ready lifts the stall.
   always_comb begin
      pc_en     = 1'b1;
      ifid_en   = 1'b1;
      idex_en   = 1'b1;
      exmem_en  = 1'b1;
      memwb_en  = 1'b1;
      ifid_clr  = 1'b0;
      idex_clr  = 1'b0;
      memwb_clr = 1'b0;
      halted    = 1'b0;
      if (state_q == HALT) begin
         pc_en    = 1'b0;
         ifid_en  = 1'b0;
         idex_en  = 1'b0;
         exmem_en = 1'b0;
         memwb_en = 1'b0;
         halted   = 1'b1;
      end else if (mstall) begin
         pc_en     = 1'b0;
         ifid_en   = 1'b0;
         idex_en   = 1'b0;
         exmem_en  = 1'b0;
         memwb_clr = 1'b1;
      end else if (ex_branch_taken) begin
         ifid_clr = 1'b1;
         idex_clr = 1'b1;
      end else if (luse) begin
         pc_en    = 1'b0;
         ifid_en  = 1'b0;
         idex_clr = 1'b1;
      end
   end

   assign in_halt   = (state_q == HALT);
   assign stall_inc = !pc_en && !in_halt;
   assign flush_inc = ifid_clr;

   sat_counter #(
      .W (CNT_W)
   ) u_stall_cnt (
      .clk    (clk),
      .rst    (rst),
      .inc    (stall_inc),
      .freeze (in_halt),
      .cnt    (stall_cnt)
   );

   sat_counter #(
      .W (CNT_W)
   ) u_flush_cnt (
      .clk    (clk),
      .rst    (rst),
      .inc    (flush_inc),
      .freeze (in_halt),
      .cnt    (flush_cnt)
   );

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Scoreboard bench for pipeline_ctrl: directed cycles push expected outputs,
// a negedge monitor pops and compares them against the DUT.
module tb_pipeline_ctrl;

   localparam int TIMEOUT = 4;
   localparam int CNT_W   = 3;

   localparam logic [4:0] EN_ALL  = 5'b11111;
   localparam logic [4:0] EN_LU   = 5'b00111;
   localparam logic [4:0] EN_MEM  = 5'b00001;
   localparam logic [4:0] EN_NONE = 5'b00000;
   localparam logic [2:0] CL_NONE = 3'b000;
   localparam logic [2:0] CL_BR   = 3'b110;
   localparam logic [2:0] CL_LU   = 3'b010;
   localparam logic [2:0] CL_MEM  = 3'b001;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic [4:0] id_rs1 = '0, id_rs2 = '0, ex_rd = '0;
   logic id_uses_rs1 = 1'b0, id_uses_rs2 = 1'b0;
   logic ex_mem_read = 1'b0, ex_branch_taken = 1'b0, mem_req = 1'b0, mem_ready = 1'b0;
   logic pc_en, ifid_en, idex_en, exmem_en, memwb_en;
   logic ifid_clr, idex_clr, memwb_clr, halted;
   logic [CNT_W-1:0] stall_cnt, flush_cnt;

   pipeline_ctrl #(
      .TIMEOUT (TIMEOUT),
      .CNT_W   (CNT_W)
   ) dut (
      .clk             (clk),
      .rst             (rst),
      .id_rs1          (id_rs1),
      .id_rs2          (id_rs2),
      .id_uses_rs1     (id_uses_rs1),
      .id_uses_rs2     (id_uses_rs2),
      .ex_rd           (ex_rd),
      .ex_mem_read     (ex_mem_read),
      .ex_branch_taken (ex_branch_taken),
      .mem_req         (mem_req),
      .mem_ready       (mem_ready),
      .pc_en           (pc_en),
      .ifid_en         (ifid_en),
      .idex_en         (idex_en),
      .exmem_en        (exmem_en),
      .memwb_en        (memwb_en),
      .ifid_clr        (ifid_clr),
      .idex_clr        (idex_clr),
      .memwb_clr       (memwb_clr),
      .halted          (halted),
      .stall_cnt       (stall_cnt),
      .flush_cnt       (flush_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      string            name;
      logic [4:0]       en;
      logic [2:0]       clr;
      logic             halt;
      logic [CNT_W-1:0] stall;
      logic [CNT_W-1:0] flush;
   } exp_t;

   exp_t exp_q[$];
   int   total = 0;
   int   bad   = 0;

   task automatic chk(input string n, input string f, input logic [7:0] act, input logic [7:0] want);
      total++;
      if (act !== want) begin
         bad++;
         $display("FAIL %s.%s got=%b want=%b", n, f, act, want);
      end
   endtask

   // Monitor: outputs are valid every cycle, so one entry is checked per negedge.
   exp_t mon_e;
   always @(negedge clk) begin
      if (exp_q.size() != 0) begin
         mon_e = exp_q.pop_front();
         chk(mon_e.name, "en", {3'b0, pc_en, ifid_en, idex_en, exmem_en, memwb_en}, {3'b0, mon_e.en});
         chk(mon_e.name, "clr", {5'b0, ifid_clr, idex_clr, memwb_clr}, {5'b0, mon_e.clr});
         chk(mon_e.name, "halted", {7'b0, halted}, {7'b0, mon_e.halt});
         chk(mon_e.name, "stall_cnt", {5'b0, stall_cnt}, {5'b0, mon_e.stall});
         chk(mon_e.name, "flush_cnt", {5'b0, flush_cnt}, {5'b0, mon_e.flush});
         $display("txn %-10s en=%b clr=%b halted=%b stall=%0d flush=%0d",
                  mon_e.name, {pc_en, ifid_en, idex_en, exmem_en, memwb_en},
                  {ifid_clr, idex_clr, memwb_clr}, halted, stall_cnt, flush_cnt);
      end
   end

   // One cycle: drive inputs just after the edge and queue the expected response.
   task automatic cyc(input string name, input logic r,
                      input logic [4:0] rs1, input logic [4:0] rs2,
                      input logic u1, input logic u2, input logic [4:0] rd,
                      input logic mr, input logic bt, input logic mq, input logic mrdy,
                      input logic [4:0] e_en, input logic [2:0] e_clr, input logic e_h,
                      input logic [CNT_W-1:0] e_s, input logic [CNT_W-1:0] e_f);
      exp_t e;
      @(posedge clk);
      #1;
      rst             = r;
      id_rs1          = rs1;
      id_rs2          = rs2;
      id_uses_rs1     = u1;
      id_uses_rs2     = u2;
      ex_rd           = rd;
      ex_mem_read     = mr;
      ex_branch_taken = bt;
      mem_req         = mq;
      mem_ready       = mrdy;
      e.name  = name;
      e.en    = e_en;
      e.clr   = e_clr;
      e.halt  = e_h;
      e.stall = e_s;
      e.flush = e_f;
      exp_q.push_back(e);
   endtask

   initial begin
      // Reset and idle
      cyc("rst",       1, 0, 0, 0, 0, 0, 0, 0, 0, 0, EN_ALL, CL_NONE, 0, 0, 0);
      cyc("rst",       1, 0, 0, 0, 0, 0, 0, 0, 0, 0, EN_ALL, CL_NONE, 0, 0, 0);
      cyc("idle",      0, 0, 0, 0, 0, 0, 0, 0, 0, 0, EN_ALL, CL_NONE, 0, 0, 0);
      // Load-use and its one-cycle bubble
      cyc("luse_rs2",  0, 0, 5, 0, 1, 5, 1, 0, 0, 0, EN_LU,  CL_LU,   0, 0, 0);
      cyc("bubble",    0, 0, 5, 0, 1, 5, 0, 0, 0, 0, EN_ALL, CL_NONE, 0, 1, 0);
      cyc("rd_zero",   0, 0, 0, 1, 0, 0, 1, 0, 0, 0, EN_ALL, CL_NONE, 0, 1, 0);
      cyc("no_use",    0, 5, 0, 0, 0, 5, 1, 0, 0, 0, EN_ALL, CL_NONE, 0, 1, 0);
      cyc("luse_rs1",  0, 7, 0, 1, 0, 7, 1, 0, 0, 0, EN_LU,  CL_LU,   0, 1, 0);
      cyc("bubble2",   0, 0, 0, 0, 0, 0, 0, 0, 0, 0, EN_ALL, CL_NONE, 0, 2, 0);
      // Taken branch, and branch beating load-use
      cyc("branch",    0, 0, 0, 0, 0, 0, 0, 1, 0, 0, EN_ALL, CL_BR,   0, 2, 0);
      cyc("after_br",  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, EN_ALL, CL_NONE, 0, 2, 1);
      cyc("br_luse",   0, 0, 5, 0, 1, 5, 1, 1, 0, 0, EN_ALL, CL_BR,   0, 2, 1);
      cyc("after_br2", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, EN_ALL, CL_NONE, 0, 2, 2);
      cyc("mem_fast",  0, 0, 0, 0, 0, 0, 0, 0, 1, 1, EN_ALL, CL_NONE, 0, 2, 2);
      // Memory wait with a held branch: exactly one flush after mem_ready
      cyc("rst",       1, 0, 0, 0, 0, 0, 0, 0, 0, 0, EN_ALL, CL_NONE, 0, 0, 0);
      cyc("mwait0",    0, 0, 0, 0, 0, 0, 0, 1, 1, 0, EN_MEM, CL_MEM,  0, 0, 0);
      cyc("mwait1",    0, 0, 0, 0, 0, 0, 0, 1, 1, 0, EN_MEM, CL_MEM,  0, 1, 0);
      cyc("mwait2",    0, 0, 0, 0, 0, 0, 0, 1, 1, 0, EN_MEM, CL_MEM,  0, 2, 0);
      cyc("mready",    0, 0, 0, 0, 0, 0, 0, 1, 1, 1, EN_ALL, CL_BR,   0, 3, 0);
      cyc("post1",     0, 0, 0, 0, 0, 0, 0, 0, 0, 0, EN_ALL, CL_NONE, 0, 3, 1);
      cyc("post2",     0, 0, 0, 0, 0, 0, 0, 0, 0, 0, EN_ALL, CL_NONE, 0, 3, 1);
      // Watchdog: HALT after exactly 4 stalled cycles, counters frozen
      cyc("rst",       1, 0, 0, 0, 0, 0, 0, 0, 0, 0, EN_ALL, CL_NONE, 0, 0, 0);
      cyc("wd0",       0, 0, 0, 0, 0, 0, 0, 0, 1, 0, EN_MEM, CL_MEM,  0, 0, 0);
      cyc("wd1_luse",  0, 0, 5, 0, 1, 5, 1, 0, 1, 0, EN_MEM, CL_MEM,  0, 1, 0);
      cyc("wd2",       0, 0, 0, 0, 0, 0, 0, 0, 1, 0, EN_MEM, CL_MEM,  0, 2, 0);
      cyc("wd3",       0, 0, 0, 0, 0, 0, 0, 0, 1, 0, EN_MEM, CL_MEM,  0, 3, 0);
      cyc("halt1",     0, 0, 0, 0, 0, 0, 0, 0, 1, 0, EN_NONE, CL_NONE, 1, 4, 0);
      cyc("halt_br",   0, 0, 5, 0, 1, 5, 1, 1, 0, 0, EN_NONE, CL_NONE, 1, 4, 0);
      cyc("halt_idle", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, EN_NONE, CL_NONE, 1, 4, 0);
      cyc("rst_halt",  1, 0, 0, 0, 0, 0, 0, 0, 0, 0, EN_ALL, CL_NONE, 0, 0, 0);
      cyc("idle",      0, 0, 0, 0, 0, 0, 0, 0, 0, 0, EN_ALL, CL_NONE, 0, 0, 0);
      // Reset mid-WAIT restarts the watchdog from zero
      cyc("w0",        0, 0, 0, 0, 0, 0, 0, 0, 1, 0, EN_MEM, CL_MEM,  0, 0, 0);
      cyc("w1",        0, 0, 0, 0, 0, 0, 0, 0, 1, 0, EN_MEM, CL_MEM,  0, 1, 0);
      cyc("rst_wait",  1, 0, 0, 0, 0, 0, 0, 0, 1, 0, EN_MEM, CL_MEM,  0, 0, 0);
      cyc("w2_0",      0, 0, 0, 0, 0, 0, 0, 0, 1, 0, EN_MEM, CL_MEM,  0, 0, 0);
      cyc("w2_1",      0, 0, 0, 0, 0, 0, 0, 0, 1, 0, EN_MEM, CL_MEM,  0, 1, 0);
      cyc("w2_2",      0, 0, 0, 0, 0, 0, 0, 0, 1, 0, EN_MEM, CL_MEM,  0, 2, 0);
      cyc("w2_3",      0, 0, 0, 0, 0, 0, 0, 0, 1, 0, EN_MEM, CL_MEM,  0, 3, 0);
      cyc("halt2",     0, 0, 0, 0, 0, 0, 0, 0, 1, 0, EN_NONE, CL_NONE, 1, 4, 0);
      // Saturation: 10 load-use events into a 3-bit stall counter
      cyc("rst",       1, 0, 0, 0, 0, 0, 0, 0, 0, 0, EN_ALL, CL_NONE, 0, 0, 0);
      for (int k = 1; k <= 10; k++) begin
         cyc("sat_luse", 0, 0, 5, 0, 1, 5, 1, 0, 0, 0, EN_LU, CL_LU, 0,
             CNT_W'((k - 1 > 7) ? 7 : k - 1), 0);
         cyc("sat_bub",  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, EN_ALL, CL_NONE, 0,
             CNT_W'((k > 7) ? 7 : k), 0);
      end
      cyc("sat_end",   0, 0, 0, 0, 0, 0, 0, 0, 0, 0, EN_ALL, CL_NONE, 0, 7, 0);

      for (int i = 0; i < 20 && exp_q.size() != 0; i++) begin
         @(posedge clk);
      end
      if (exp_q.size() != 0) begin
         total++;
         bad++;
         $display("FAIL drain left=%0d want=0", exp_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
